// File: rtl/pellet_tracker.sv
// rtl/pellet_tracker.sv - eat detection, score/pellet accounting and level respawn sequencing
module pellet_tracker #(
    parameter int N_COOKIES   = 64,
    parameter int POINTS      = 10,
    parameter int SCORE_W     = 16,
    parameter int CLEAR_DELAY = 60
) (
    input  logic                               Clk,
    input  logic                               Reset_n,
    input  logic                               Frame_tick,
    input  logic                               Start,
    input  logic [N_COOKIES-1:0]               Not_ate,
    output logic                               Cookie_reset,
    output logic [SCORE_W-1:0]                 Score,
    output logic [$clog2(N_COOKIES+1)-1:0]     Remaining,
    output logic [7:0]                         Level,
    output logic                               Eat_pulse,
    output logic                               Level_clear
);

    localparam int REM_W = $clog2(N_COOKIES + 1);
    localparam int SUM_W = SCORE_W + REM_W + $clog2(POINTS + 1);
    localparam int CNT_W = $clog2(CLEAR_DELAY + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESPAWN,
        S_SETTLE,
        S_PLAY,
        S_CLEAR_WAIT
    } state_t;

    state_t                 r_state;
    logic [N_COOKIES-1:0]   r_not_ate_q;
    logic [SCORE_W-1:0]     r_score;
    logic [REM_W-1:0]       r_remaining;
    logic [7:0]             r_level;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_eat_pulse;
    logic                   r_level_clear;
    logic                   r_cookie_reset;

    logic [N_COOKIES-1:0]   w_eat_vec;
    logic [REM_W-1:0]       w_k;
    logic [SUM_W-1:0]       w_sum;
    logic [SCORE_W-1:0]     w_score_next;
    logic [REM_W-1:0]       w_rem_next;

    // Count cookies that vanished this cycle and form saturating score / floored remaining.
    always_comb begin
        w_eat_vec = r_not_ate_q & ~Not_ate;
        w_k       = '0;
        for (int i = 0; i < N_COOKIES; i++) begin
            w_k = w_k + REM_W'(w_eat_vec[i]);
        end
        w_sum        = SUM_W'(r_score) + SUM_W'(w_k) * SUM_W'(POINTS);
        w_score_next = (w_sum > SUM_W'({SCORE_W{1'b1}})) ? {SCORE_W{1'b1}} : w_sum[SCORE_W-1:0];
        w_rem_next   = (w_k >= r_remaining) ? '0 : r_remaining - w_k;
    end

    // Level sequencing FSM with all outputs registered.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state        <= S_IDLE;
            r_not_ate_q    <= '1;
            r_score        <= '0;
            r_remaining    <= '0;
            r_level        <= '0;
            r_cnt          <= '0;
            r_eat_pulse    <= 1'b0;
            r_level_clear  <= 1'b0;
            r_cookie_reset <= 1'b0;
        end else begin
            r_eat_pulse    <= 1'b0;
            r_cookie_reset <= 1'b0;
            r_not_ate_q    <= Not_ate;
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_score        <= '0;
                        r_level        <= 8'd1;
                        r_cookie_reset <= 1'b1;
                        r_state        <= S_RESPAWN;
                    end
                end
                S_RESPAWN: begin
                    // Cookies are respawning; their flags may still be low, so mask them.
                    r_remaining <= REM_W'(N_COOKIES);
                    r_not_ate_q <= '1;
                    r_state     <= S_SETTLE;
                end
                S_SETTLE: begin
                    r_not_ate_q <= '1;
                    r_state     <= S_PLAY;
                end
                S_PLAY: begin
                    if (w_k != '0) begin
                        r_score     <= w_score_next;
                        r_remaining <= w_rem_next;
                        r_eat_pulse <= 1'b1;
                    end
                    if (r_remaining == '0) begin
                        r_level_clear <= 1'b1;
                        r_state       <= S_CLEAR_WAIT;
                    end
                end
                S_CLEAR_WAIT: begin
                    if (r_cnt == CNT_W'(CLEAR_DELAY)) begin
                        r_cnt          <= '0;
                        r_level        <= (r_level == 8'hFF) ? 8'hFF : r_level + 8'd1;
                        r_level_clear  <= 1'b0;
                        r_cookie_reset <= 1'b1;
                        r_state        <= S_RESPAWN;
                    end else if (Frame_tick) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Cookie_reset = r_cookie_reset;
    assign Score        = r_score;
    assign Remaining    = r_remaining;
    assign Level        = r_level;
    assign Eat_pulse    = r_eat_pulse;
    assign Level_clear  = r_level_clear;

endmodule

// File: tb/tb_pellet_tracker.sv
// tb/tb_pellet_tracker.sv - directed bench for pellet_tracker (16-bit and 8-bit score instances)
module tb_pellet_tracker;

    logic        Clk;
    logic        Reset_n;
    logic        Frame_tick;
    logic        Start;
    logic [63:0] Not_ate;

    logic        a_cookie_reset, b_cookie_reset;
    logic [15:0] a_score;
    logic [7:0]  b_score;
    logic [6:0]  a_remaining, b_remaining;
    logic [7:0]  a_level, b_level;
    logic        a_eat_pulse, b_eat_pulse;
    logic        a_level_clear, b_level_clear;

    int checks = 0;
    int errors = 0;
    int pulses;

    pellet_tracker #(.N_COOKIES(64), .POINTS(10), .SCORE_W(16), .CLEAR_DELAY(60)) u_a (
        .Clk(Clk), .Reset_n(Reset_n), .Frame_tick(Frame_tick), .Start(Start), .Not_ate(Not_ate),
        .Cookie_reset(a_cookie_reset), .Score(a_score), .Remaining(a_remaining), .Level(a_level),
        .Eat_pulse(a_eat_pulse), .Level_clear(a_level_clear)
    );

    pellet_tracker #(.N_COOKIES(64), .POINTS(10), .SCORE_W(8), .CLEAR_DELAY(60)) u_b (
        .Clk(Clk), .Reset_n(Reset_n), .Frame_tick(Frame_tick), .Start(Start), .Not_ate(Not_ate),
        .Cookie_reset(b_cookie_reset), .Score(b_score), .Remaining(b_remaining), .Level(b_level),
        .Eat_pulse(b_eat_pulse), .Level_clear(b_level_clear)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        Reset_n    = 1'b0;
        Frame_tick = 1'b0;
        Start      = 1'b0;
        Not_ate    = '1;
        step();
        step();
        chk("rst_score", a_score, 0);
        chk("rst_remaining", a_remaining, 0);
        chk("rst_level", a_level, 0);
        chk("rst_outs", {a_eat_pulse, a_level_clear, a_cookie_reset}, 0);
        Reset_n = 1'b1;
        step();

        // Start: one Cookie_reset pulse, then Remaining=64 in SETTLE, PLAY after.
        Start = 1'b1;
        step();
        Start = 1'b0;
        chk("start_cookie_reset", a_cookie_reset, 1);
        chk("start_level", a_level, 1);
        chk("start_score", a_score, 0);
        step();
        chk("settle_cookie_reset", a_cookie_reset, 0);
        chk("settle_remaining", a_remaining, 64);
        step();
        chk("play_no_eat", a_eat_pulse, 0);

        // Single eat on bit 5, visible at the same edge it is sampled.
        Not_ate[5] = 1'b0;
        step();
        chk("eat5_score", a_score, 10);
        chk("eat5_remaining", a_remaining, 63);
        chk("eat5_pulse", a_eat_pulse, 1);
        step();
        chk("eat5_pulse_once", a_eat_pulse, 0);
        chk("eat5_score_hold", a_score, 10);

        // Three simultaneous eats.
        Not_ate[2:0] = 3'b000;
        step();
        chk("eat3_score", a_score, 40);
        chk("eat3_remaining", a_remaining, 60);
        chk("eat3_pulse", a_eat_pulse, 1);
        step();
        chk("eat3_pulse_once", a_eat_pulse, 0);

        // Bits 6..26 one per cycle: score reaches 250 on both instances.
        for (int i = 6; i <= 26; i++) begin
            Not_ate[i] = 1'b0;
            step();
        end
        chk("b_score_250", b_score, 250);
        chk("a_score_250", a_score, 250);
        chk("remaining_39", a_remaining, 39);

        // 8-bit score saturates; 16-bit keeps counting.
        Not_ate[27] = 1'b0;
        step();
        chk("b_score_sat", b_score, 255);
        chk("a_score_260", a_score, 260);
        Not_ate[28] = 1'b0;
        step();
        chk("b_score_sat_hold", b_score, 255);
        chk("a_score_270", a_score, 270);
        chk("remaining_37", a_remaining, 37);

        // Eat the remaining 37 at once.
        Not_ate = '0;
        step();
        chk("clear_remaining", a_remaining, 0);
        chk("clear_score", a_score, 640);
        chk("clear_level_clear_lag", a_level_clear, 0);
        step();
        chk("level_clear_on", a_level_clear, 1);

        // 60 frame ticks in CLEAR_WAIT; flags rising here are ignored.
        Not_ate = '1;
        pulses  = 0;
        for (int i = 0; i < 60; i++) begin
            Frame_tick = 1'b1;
            step();
            Frame_tick = 1'b0;
            pulses += int'(a_cookie_reset);
            if (i == 30) chk("wait_level_clear", a_level_clear, 1);
        end
        chk("wait_no_respawn", pulses, 0);
        chk("wait_remaining", a_remaining, 0);
        step();
        chk("respawn_pulse", a_cookie_reset, 1);
        chk("respawn_level", a_level, 2);
        chk("respawn_level_clear_off", a_level_clear, 0);
        chk("respawn_score_kept", a_score, 640);
        step();
        chk("respawn_pulse_once", a_cookie_reset, 0);
        chk("respawn_remaining", a_remaining, 64);
        step();
        chk("play2_score", a_score, 640);
        chk("play2_no_eat", a_eat_pulse, 0);

        // Clear level 2 in one cycle, then reset at tick 30 of CLEAR_WAIT.
        Not_ate = '0;
        step();
        chk("lvl2_score", a_score, 1280);
        chk("lvl2_remaining", a_remaining, 0);
        step();
        chk("lvl2_level_clear", a_level_clear, 1);
        for (int i = 0; i < 30; i++) begin
            Frame_tick = 1'b1;
            step();
            Frame_tick = 1'b0;
        end
        #2;
        Reset_n = 1'b0;
        #1;
        chk("async_rst_score", a_score, 0);
        chk("async_rst_level", a_level, 0);
        chk("async_rst_outs", {a_eat_pulse, a_level_clear, a_cookie_reset, 7'(a_remaining)}, 0);
        step();
        Reset_n = 1'b1;
        Not_ate = '1;
        pulses  = 0;
        for (int i = 0; i < 80; i++) begin
            Frame_tick = (i % 2 == 0);
            step();
            pulses += int'(a_cookie_reset);
        end
        Frame_tick = 1'b0;
        chk("idle_no_respawn", pulses, 0);
        chk("idle_level", a_level, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
